// File: rtl/spram16x64_rr_arb.sv
// Round-robin arbiter that shares one single-port 16x64 SRAM macro between two requesters.
// Latency: the grant is combinational in the request cycle, and read data returns exactly 1 cycle later.
// Backpressure: reqN_ready drops for the losing requester. Responses cannot be stalled.
module spram16x64_rr_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    logic       prio;
    logic [1:0] rd_pend;
    logic       grant0;
    logic       grant1;

    // Grants are gated with rst_n so that the macro stays deselected while reset is held.
    always_comb begin
        grant0 = rst_n & req0_valid & (~req1_valid | ~prio);
        grant1 = rst_n & req1_valid & (~req0_valid | prio);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (grant0) begin
            sram_ceb = 1'b0;
            sram_web = ~req0_we;
            sram_a   = req0_addr;
            sram_d   = req0_wdata;
        end else if (grant1) begin
            sram_ceb = 1'b0;
            sram_web = ~req1_we;
            sram_a   = req1_addr;
            sram_d   = req1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= {grant1 & ~req1_we, grant0 & ~req0_we};
            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end
        end
    end

    // The macro output is held at zero toward a requester unless its read is returning.
    assign rsp0_valid = rd_pend[0];
    assign rsp1_valid = rd_pend[1];
    assign rsp0_rdata = rd_pend[0] ? sram_q : '0;
    assign rsp1_rdata = rd_pend[1] ? sram_q : '0;

endmodule

// File: tb/tb_spram16x64_rr_arb.sv
// Self-checking bench for spram16x64_rr_arb, with a behavioural macro and a reference memory scoreboard.
module tb_spram16x64_rr_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0]  req0_addr = '0, req1_addr = '0;
    logic [63:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic        sram_ceb, sram_web;
    logic [3:0]  sram_a;
    logic [63:0] sram_d;
    logic [63:0] sram_q = '0;
    logic [63:0] mem [16] = '{default: '0};

    logic [63:0] ref_mem [16];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] exp_d;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural model of the std_spram16x64 macro.
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else sram_q <= mem[sram_a];
        end
    end

    spram16x64_rr_arb #(.ADDR_W(4), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    task automatic drive(input logic v0, input logic we0, input logic [3:0] a0, input logic [63:0] d0,
                         input logic v1, input logic we1, input logic [3:0] a1, input logic [63:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        rst_n = 1'b0;
        drive(1, 0, 4'd5, 64'd0, 1, 0, 4'd6, 64'd0);
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {req1_ready, req0_ready}); end
        n_checks++; if ({sram_ceb, sram_web} !== 2'b11) begin n_fail++; $display("FAIL rst_ceb_web: got %b want 11", {sram_ceb, sram_web}); end
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp: got %b want 00", {rsp1_valid, rsp0_valid}); end
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_write_read();
        drive(1, 1, 4'd3, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b want 01", {req1_ready, req0_ready}); end
        n_checks++; if ({sram_ceb, sram_web, sram_a} !== {2'b00, 4'd3}) begin n_fail++; $display("FAIL wr_pins: got %b want 00_0011", {sram_ceb, sram_web, sram_a}); end
        n_checks++; if (sram_d !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL wr_data: got %h want deadbeef01234567", sram_d); end
        ref_mem[3] = 64'hDEAD_BEEF_0123_4567;
        next_cycle();
        drive(1, 0, 4'd3, 64'd0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({req0_ready, sram_ceb, sram_web} !== 3'b101) begin n_fail++; $display("FAIL rd_pins: got %b want 101", {req0_ready, sram_ceb, sram_web}); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", rsp0_valid); end
        q0.push_back(ref_mem[3]);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 01", {rsp1_valid, rsp0_valid}); end
        exp_d = (q0.size() > 0) ? q0.pop_front() : 64'hX;
        n_checks++; if (rsp0_rdata !== exp_d) begin n_fail++; $display("FAIL rd_rsp_data: got %h want %h", rsp0_rdata, exp_d); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({rsp0_valid, rsp0_rdata} !== 65'd0) begin n_fail++; $display("FAIL rd_rsp_clear: got %b/%h want 0/0", rsp0_valid, rsp0_rdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        int a0 [3] = '{0, 1, 2};
        int a1 [3] = '{8, 9, 10};
        int pre [6] = '{0, 1, 2, 8, 9, 10};
        int i0 = 0, i1 = 0, win = 0, prev = -1;
        logic [1:0] want;
        // Preload through requester 1 so that its last grant leaves the priority pointing at requester 0.
        foreach (pre[k]) begin
            drive(0, 0, 0, 0, 1, 1, pre[k][3:0], 64'h5A00_0000_0000_0000 + 64'(pre[k]));
            @(negedge clk);
            n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL pre_ready1[%0d]: got %b want 1", k, req1_ready); end
            ref_mem[pre[k]] = 64'h5A00_0000_0000_0000 + 64'(pre[k]);
            next_cycle();
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 6) drive(1, 0, a0[i0][3:0], 0, 1, 0, a1[i1][3:0], 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c < 6) begin
                want = (win == 0) ? 2'b01 : 2'b10;
                n_checks++; if ({req1_ready, req0_ready} !== want) begin n_fail++; $display("FAIL cont_grant[%0d]: got %b want %b", c, {req1_ready, req0_ready}, want); end
            end
            if (prev >= 0) begin
                want = (prev == 0) ? 2'b01 : 2'b10;
                n_checks++; if ({rsp1_valid, rsp0_valid} !== want) begin n_fail++; $display("FAIL cont_rsp[%0d]: got %b want %b", c, {rsp1_valid, rsp0_valid}, want); end
                if (prev == 0) begin
                    exp_d = (q0.size() > 0) ? q0.pop_front() : 64'hX;
                    n_checks++; if (rsp0_rdata !== exp_d) begin n_fail++; $display("FAIL cont_data0[%0d]: got %h want %h", c, rsp0_rdata, exp_d); end
                end else begin
                    exp_d = (q1.size() > 0) ? q1.pop_front() : 64'hX;
                    n_checks++; if (rsp1_rdata !== exp_d) begin n_fail++; $display("FAIL cont_data1[%0d]: got %h want %h", c, rsp1_rdata, exp_d); end
                end
            end
            if (c < 6) begin
                if (win == 0) begin q0.push_back(ref_mem[a0[i0]]); i0++; end
                else begin q1.push_back(ref_mem[a1[i1]]); i1++; end
                prev = win;
                win = 1 - win;
            end
            next_cycle();
        end
    endtask

    task automatic test_wr_rd_pair();
        drive(0, 0, 0, 0, 1, 1, 4'd15, 64'h1);
        @(negedge clk);
        n_checks++; if ({req1_ready, sram_web} !== 2'b10) begin n_fail++; $display("FAIL pair_wr: got %b want 10", {req1_ready, sram_web}); end
        ref_mem[15] = 64'h1;
        next_cycle();
        drive(1, 0, 4'd15, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({req0_ready, rsp1_valid} !== 2'b10) begin n_fail++; $display("FAIL pair_rd: got %b want 10", {req0_ready, rsp1_valid}); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b1, 64'h1}) begin n_fail++; $display("FAIL pair_rsp: got %b/%h want 1/1", rsp0_valid, rsp0_rdata); end
        next_cycle();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({sram_ceb, sram_web, sram_a, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== {2'b11, 8'h00}) begin
                n_fail++; $display("FAIL idle[%0d]: ceb/web %b%b a %h rsp %b%b rdy %b%b want 11 0 00 00", c, sram_ceb, sram_web, sram_a, rsp1_valid, rsp0_valid, req1_ready, req0_ready);
            end
            next_cycle();
        end
        // The last grant went to requester 0, so requester 1 must win this tie.
        drive(1, 0, 4'd1, 0, 1, 0, 4'd2, 0);
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL idle_prio: got %b want 10", {req1_ready, req0_ready}); end
        q1.push_back(ref_mem[2]);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        exp_d = (q1.size() > 0) ? q1.pop_front() : 64'hX;
        n_checks++; if ({rsp1_valid, rsp1_rdata} !== {1'b1, exp_d}) begin n_fail++; $display("FAIL idle_rsp: got %b/%h want 1/%h", rsp1_valid, rsp1_rdata, exp_d); end
        next_cycle();
    endtask

    task automatic test_reset_pending();
        drive(1, 0, 4'd3, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_grant: got %b want 1", req0_ready); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== 66'd0) begin n_fail++; $display("FAIL rstp_rsp: got %b%b/%h want 00/0", rsp0_valid, rsp1_valid, rsp0_rdata); end
        n_checks++; if ({sram_ceb, sram_web, req0_ready} !== 3'b110) begin n_fail++; $display("FAIL rstp_pins: got %b want 110", {sram_ceb, sram_web, req0_ready}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL rstp_drop: got %b want 00", {rsp1_valid, rsp0_valid}); end
        next_cycle();
        drive(1, 0, 4'd8, 0, 1, 0, 4'd9, 0);
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rstp_prio: got %b want 01", {req1_ready, req0_ready}); end
        q0.push_back(ref_mem[8]);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        exp_d = (q0.size() > 0) ? q0.pop_front() : 64'hX;
        n_checks++; if ({rsp0_valid, rsp0_rdata} !== {1'b1, exp_d}) begin n_fail++; $display("FAIL rstp_rsp0: got %b/%h want 1/%h", rsp0_valid, rsp0_rdata, exp_d); end
        next_cycle();
    endtask

    task automatic test_soak();
        logic act0 = 0, act1 = 0;
        logic [1:0] exp_pend = 2'b00, nxt_pend;
        int w0 = 0, w1 = 0, issued = 0, cyc = 0;
        while (issued < 10000 && cyc < 40000) begin
            if (!act0 && $urandom_range(3) != 0) begin
                act0 = 1; req0_we = $urandom_range(1); req0_addr = 4'($urandom_range(15)); req0_wdata = {$urandom, $urandom};
            end
            if (!act1 && $urandom_range(3) != 0) begin
                act1 = 1; req1_we = $urandom_range(1); req1_addr = 4'($urandom_range(15)); req1_wdata = {$urandom, $urandom};
            end
            req0_valid = act0; req1_valid = act1;
            @(negedge clk);
            n_checks++; if ({rsp1_valid, rsp0_valid} !== exp_pend) begin n_fail++; $display("FAIL soak_rsp_valid[%0d]: got %b want %b", cyc, {rsp1_valid, rsp0_valid}, exp_pend); end
            exp_d = rsp0_valid ? ((q0.size() > 0) ? q0.pop_front() : 64'hX) : 64'd0;
            n_checks++; if (rsp0_rdata !== exp_d) begin n_fail++; $display("FAIL soak_data0[%0d]: got %h want %h", cyc, rsp0_rdata, exp_d); end
            exp_d = rsp1_valid ? ((q1.size() > 0) ? q1.pop_front() : 64'hX) : 64'd0;
            n_checks++; if (rsp1_rdata !== exp_d) begin n_fail++; $display("FAIL soak_data1[%0d]: got %h want %h", cyc, rsp1_rdata, exp_d); end
            n_checks++;
            if ((req0_ready && !act0) || (req1_ready && !act1) || (req0_ready && req1_ready) ||
                ((act0 || act1) && !(req0_ready || req1_ready)) || (sram_ceb !== !(req0_ready || req1_ready))) begin
                n_fail++; $display("FAIL soak_grant[%0d]: vld %b%b rdy %b%b ceb %b", cyc, act1, act0, req1_ready, req0_ready, sram_ceb);
            end
            nxt_pend = 2'b00;
            if (act0 && req0_ready) begin
                n_checks++; if (w0 > 1) begin n_fail++; $display("FAIL soak_wait0[%0d]: got %0d want <=1", cyc, w0); end
                if (req0_we) ref_mem[req0_addr] = req0_wdata;
                else begin q0.push_back(ref_mem[req0_addr]); nxt_pend[0] = 1'b1; end
                act0 = 0; w0 = 0; issued++;
            end else if (act0) w0++;
            if (act1 && req1_ready) begin
                n_checks++; if (w1 > 1) begin n_fail++; $display("FAIL soak_wait1[%0d]: got %0d want <=1", cyc, w1); end
                if (req1_we) ref_mem[req1_addr] = req1_wdata;
                else begin q1.push_back(ref_mem[req1_addr]); nxt_pend[1] = 1'b1; end
                act1 = 0; w1 = 0; issued++;
            end else if (act1) w1++;
            exp_pend = nxt_pend;
            cyc++;
            next_cycle();
        end
        n_checks++; if (issued < 10000) begin n_fail++; $display("FAIL soak_budget: got %0d commands want 10000", issued); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== exp_pend) begin n_fail++; $display("FAIL soak_tail: got %b want %b", {rsp1_valid, rsp0_valid}, exp_pend); end
        if (rsp0_valid && q0.size() > 0) void'(q0.pop_front());
        if (rsp1_valid && q1.size() > 0) void'(q1.pop_front());
        n_checks++; if (q0.size() + q1.size() != 0) begin n_fail++; $display("FAIL soak_drain: got %0d left want 0", q0.size() + q1.size()); end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        test_reset_state();
        test_write_read();
        test_contention();
        test_wr_rd_pair();
        test_idle();
        test_reset_pending();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
